bf_pc_sequencer: RTL and testbench
==================================

BF_PC_SEQUENCER -- requirements
Module: bf_pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, program-counter and ROM-address width.
REQ-002 Parameter DEPTH_W, default 10, bracket-nesting counter width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse; starts or restarts the program at address 0 from IDLE or HALT.
REQ-006 rom_addr  output  ADDR_W  program ROM address, equal to PC.
REQ-007 rom_code  input  3  opcode returned combinationally by the ROM for rom_addr.
REQ-008 rom_overrun  input  1  ROM flag: rom_addr is at or beyond program length.
REQ-009 cell_zero  input  1  current data cell equals 0; valid for all ops accepted before this cycle.
REQ-010 op_valid  output  1  a non-bracket opcode is offered to the execute unit.
REQ-011 op_code  output  3  offered opcode (+ - > < . ,).
REQ-012 op_ready  input  1  execute unit accepts op_code this cycle.
REQ-013 busy  output  1  state is RUN, SCAN_FWD or SCAN_BACK.
REQ-014 halted  output  1  state is HALT.
REQ-015 unmatched_err  output  1  sticky flag: bracket scan failed to find its partner.

Function
REQ-016 States: IDLE, RUN, SCAN_FWD, SCAN_BACK, HALT; held in a PC register, a depth counter and an error flag.
REQ-017 IDLE/HALT: start -> PC=0, depth=0, unmatched_err=0, state RUN; start is ignored in RUN and scan states.
REQ-018 RUN, rom_overrun=1 -> HALT, PC held, op_valid=0.
REQ-019 RUN, code + - > < . , -> op_valid=1 and op_code=rom_code combinationally (zero latency); PC+1 only on a cycle with op_valid and op_ready; PC holds otherwise.
REQ-020 RUN, code [ with cell_zero=0 -> PC+1; with cell_zero=1 -> depth=1, PC+1, SCAN_FWD; op_valid=0.
REQ-021 RUN, code ] with cell_zero=1 -> PC+1; with cell_zero=0 -> depth=1, PC-1, SCAN_BACK; op_valid=0.
REQ-022 SCAN_FWD, one address per cycle: [ -> depth+1; ] with depth=1 -> PC+1, RUN; ] otherwise -> depth-1; other codes unchanged; PC+1 unless returning.
REQ-023 SCAN_FWD with rom_overrun=1 -> HALT, unmatched_err=1.
REQ-024 SCAN_BACK, one address per cycle: ] -> depth+1; [ with depth=1 -> PC+1, RUN; [ otherwise -> depth-1; PC-1 unless returning.
REQ-025 SCAN_BACK at PC=0 with no match -> HALT, unmatched_err=1; PC never wraps below 0.
REQ-026 Depth reaching 2^DEPTH_W-1 and incrementing -> HALT, unmatched_err=1.
REQ-027 op_valid=0 in every state except RUN; op_ready is ignored when op_valid=0.
REQ-028 PC increments in RUN saturate at 2^ADDR_W-1; rom_overrun halts before wrap.

Reset
REQ-029 rst -> state IDLE, PC=0, depth=0, unmatched_err=0, op_valid=0, busy=0, halted=0 on the next edge, from any state, including mid-scan.
REQ-030 rst has priority over start in the same cycle.

Structure
REQ-031 Shared package bf_pkg holds opcode constants (INC 111, DEC 110, MOVR 101, MOVL 100, IF 011, BACK 010, OUT 001, IN 000), the sequencer state enum and ADDR_W.
REQ-032 No sub-module; the scan logic is inline in the single FSM.

Verification
REQ-033 Program "+.", op_ready=1: start -> INC issued at PC 0, OUT at PC 1, HALT at PC 2, unmatched_err=0.
REQ-034 Program "+[-]." with cell model: loop runs once; ] sees cell_zero=1 and falls through; OUT is issued at PC 4; HALT at PC 5.
REQ-035 Program "[[+]+]." with cell_zero=1: SCAN_FWD passes depth 2, reaches RUN at PC 6, OUT is issued.
REQ-036 Program "+[" with cell_zero=0: RUN reaches PC 2, rom_overrun -> HALT, unmatched_err=0; Program "]" with cell_zero=0 -> SCAN_BACK from PC 0 -> HALT, unmatched_err=1.
REQ-037 op_ready held low 5 cycles on INC -> PC and op_code stable, op_valid=1 throughout; accept on cycle 6 -> PC+1.
REQ-038 rst asserted during SCAN_FWD -> IDLE, PC=0 next cycle; start after release reruns from PC 0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck program-counter sequencer.
// Opcode encodings, sequencer states and default address width.
package bf_pkg;

  localparam int ADDR_W = 10;

  localparam logic [2:0] OP_INC  = 3'b111;
  localparam logic [2:0] OP_DEC  = 3'b110;
  localparam logic [2:0] OP_MOVR = 3'b101;
  localparam logic [2:0] OP_MOVL = 3'b100;
  localparam logic [2:0] OP_IF   = 3'b011;
  localparam logic [2:0] OP_BACK = 3'b010;
  localparam logic [2:0] OP_OUT  = 3'b001;
  localparam logic [2:0] OP_IN   = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN_FWD,
    ST_SCAN_BACK,
    ST_HALT
  } seq_state_t;

endpackage

// File: rtl/bf_pc_sequencer.sv
// Program-counter sequencer: fetches opcodes, issues data ops and
// resolves bracket jumps by scanning the ROM one address per cycle.
module bf_pc_sequencer #(
  parameter int ADDR_W  = bf_pkg::ADDR_W,
  parameter int DEPTH_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_code,
  input  logic              rom_overrun,
  input  logic              cell_zero,
  output logic              op_valid,
  output logic [2:0]        op_code,
  input  logic              op_ready,
  output logic              busy,
  output logic              halted,
  output logic              unmatched_err
);
  import bf_pkg::*;

  localparam logic [ADDR_W-1:0]  PC_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEP_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEP_ONE = DEPTH_W'(1);

  seq_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic               pc_zero;

  assign pc_inc  = (pc_q == PC_MAX) ? pc_q : pc_q + 1'b1;
  assign pc_zero = (pc_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    depth_d  = depth_q;
    err_d    = err_q;
    op_valid = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          depth_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (rom_overrun) begin
          state_d = ST_HALT;
        end else if (rom_code == OP_IF) begin
          pc_d = pc_inc;
          if (cell_zero) begin
            depth_d = DEP_ONE;
            state_d = ST_SCAN_FWD;
          end
        end else if (rom_code == OP_BACK) begin
          if (cell_zero) begin
            pc_d = pc_inc;
          end else begin
            // At PC 0 the scan re-reads this ']' and fails there
            depth_d = DEP_ONE;
            state_d = ST_SCAN_BACK;
            if (!pc_zero) pc_d = pc_q - 1'b1;
          end
        end else begin
          op_valid = 1'b1;
          if (op_ready) pc_d = pc_inc;
        end
      end
      ST_SCAN_FWD: begin
        if (rom_overrun) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else if (rom_code == OP_IF) begin
          if (depth_q == DEP_MAX) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            depth_d = depth_q + 1'b1;
            pc_d    = pc_inc;
          end
        end else if (rom_code == OP_BACK) begin
          pc_d = pc_inc;
          if (depth_q == DEP_ONE) state_d = ST_RUN;
          else depth_d = depth_q - 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_SCAN_BACK: begin
        if (rom_code == OP_IF && depth_q == DEP_ONE) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end else if (pc_zero ||
                     (rom_code == OP_BACK && depth_q == DEP_MAX)) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          pc_d = pc_q - 1'b1;
          if (rom_code == OP_BACK) depth_d = depth_q + 1'b1;
          else if (rom_code == OP_IF) depth_d = depth_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rom_addr      = pc_q;
  assign op_code       = rom_code;
  assign busy          = (state_q == ST_RUN) ||
                         (state_q == ST_SCAN_FWD) ||
                         (state_q == ST_SCAN_BACK);
  assign halted        = (state_q == ST_HALT);
  assign unmatched_err = err_q;

endmodule

// File: tb/tb_bf_pc_sequencer.sv
// Randomized scoreboard bench for bf_pc_sequencer against a
// source-level brainfuck interpreter model.
module tb_bf_pc_sequencer;

  localparam int AW = 10;
  localparam int ROM_N = 64;

  typedef struct {
    int         pc;
    logic [2:0] code;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] rom_addr;
  logic [2:0]    rom_code;
  logic          rom_overrun, cell_zero;
  logic          op_valid, op_ready;
  logic [2:0]    op_code;
  logic          busy, halted, unmatched_err;

  logic [2:0] rom [ROM_N];
  int         prog_len;
  logic [7:0] tape [16];
  logic [3:0] ptr;
  int         ready_mode;
  exp_t       expq [$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign rom_code    = (int'(rom_addr) < ROM_N) ? rom[rom_addr[5:0]] : 3'b000;
  assign rom_overrun = int'(rom_addr) >= prog_len;
  assign cell_zero   = (tape[ptr] == 8'd0);

  bf_pc_sequencer #(.ADDR_W(AW), .DEPTH_W(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_code(rom_code),
    .rom_overrun(rom_overrun), .cell_zero(cell_zero),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .busy(busy), .halted(halted), .unmatched_err(unmatched_err)
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] code_of(byte c);
    case (c)
      "+": return 3'b111;
      "-": return 3'b110;
      ">": return 3'b101;
      "<": return 3'b100;
      "[": return 3'b011;
      "]": return 3'b010;
      ".": return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // ready driver, changes away from the sampling edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: op_ready = 1'b0;
      2: op_ready = 1'b1;
      default: op_ready = ($urandom_range(3) != 0);
    endcase
  end

  // monitor: every accepted op is popped and compared, then the
  // environment's data tape is updated
  always @(negedge clk) begin
    if (!rst && op_valid && op_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_op", {rom_addr, op_code}, 32'hFFFF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("op_pc_code", {rom_addr, op_code}, {e.pc[AW-1:0], e.code});
      end
      case (op_code)
        3'b111: tape[ptr] = tape[ptr] + 8'd1;
        3'b110: tape[ptr] = tape[ptr] - 8'd1;
        3'b101: ptr = ptr + 4'd1;
        3'b100: ptr = ptr - 4'd1;
        3'b000: tape[ptr] = 8'd0;
        default: ;
      endcase
    end
  end

  task automatic clear_tape();
    for (int i = 0; i < 16; i++) tape[i] = 8'd0;
    ptr = 4'd0;
  endtask

  task automatic load(string s);
    for (int i = 0; i < ROM_N; i++) rom[i] = 3'b000;
    for (int i = 0; i < s.len(); i++) rom[i] = code_of(s[i]);
    prog_len = s.len();
  endtask

  // Source-level interpreter with precomputed bracket partners
  task automatic model(input string s, output bit ok,
                       output int hpc, output bit herr);
    int   match [ROM_N];
    int   stk [$];
    exp_t loc [$];
    byte  t [16];
    int   p, pc, steps, n;
    n = s.len();
    for (int i = 0; i < ROM_N; i++) match[i] = -1;
    for (int i = 0; i < n; i++) begin
      if (s[i] == "[") stk.push_back(i);
      else if (s[i] == "]" && stk.size() > 0) begin
        int j;
        j = stk.pop_back();
        match[i] = j;
        match[j] = i;
      end
    end
    for (int i = 0; i < 16; i++) t[i] = 0;
    p = 0; pc = 0; steps = 0; ok = 1; hpc = 0; herr = 0;
    forever begin
      if (pc >= n) begin hpc = pc; herr = 0; break; end
      if (++steps > 400) begin ok = 0; break; end
      if (s[pc] == "[") begin
        if (t[p] != 0) pc++;
        else if (match[pc] < 0) begin hpc = n; herr = 1; break; end
        else pc = match[pc] + 1;
      end else if (s[pc] == "]") begin
        if (t[p] == 0) pc++;
        else if (match[pc] < 0) begin hpc = 0; herr = 1; break; end
        else pc = match[pc] + 1;
      end else begin
        exp_t e;
        e.pc = pc;
        e.code = code_of(s[pc]);
        loc.push_back(e);
        case (s[pc])
          "+": t[p] = t[p] + 1;
          "-": t[p] = t[p] - 1;
          ">": p = (p + 1) % 16;
          "<": p = (p + 15) % 16;
          ",": t[p] = 0;
          default: ;
        endcase
        pc++;
      end
    end
    if (ok) foreach (loc[i]) expq.push_back(loc[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(string name, int hpc, bit herr);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20000; i++) begin
      if (halted) begin seen = 1; break; end
      @(negedge clk);
    end
    chk({name, "_halted"}, {31'd0, seen}, 32'd1);
    chk({name, "_pc_err"}, {rom_addr, unmatched_err}, {hpc[AW-1:0], herr});
    chk({name, "_drained"}, expq.size(), 0);
    chk({name, "_not_busy"}, {31'd0, busy}, 32'd0);
    expq.delete();
  endtask

  task automatic run_prog(string s, output bit ran);
    bit ok, herr;
    int hpc;
    expq.delete();
    model(s, ok, hpc, herr);
    ran = ok;
    if (!ok) return;
    load(s);
    clear_tape();
    pulse_start();
    wait_halt(s, hpc, herr);
  endtask

  initial begin
    bit    ran;
    bit    ok, herr;
    int    hpc, done;
    string alpha;
    alpha = "+-><[].,+-.[]";
    rst = 1'b1; start = 1'b0; ready_mode = 0; op_ready = 1'b0;
    prog_len = 0;
    clear_tape();
    load("");
    repeat (3) @(negedge clk);
    chk("rst_pc", rom_addr, 0);
    chk("rst_flags", {op_valid, busy, halted, unmatched_err}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", {busy, halted}, 2'b00);

    run_prog("+.", ran);
    run_prog("+[-].", ran);
    run_prog("[[+]+].", ran);
    run_prog("+[", ran);
    run_prog("]", ran);
    run_prog("+[>++[-]<-],.", ran);

    // stall: INC held offered with no accept
    expq.delete();
    model("+.", ok, hpc, herr);
    load("+.");
    clear_tape();
    ready_mode = 1;
    @(posedge clk); #2;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {op_valid, rom_addr, op_code},
          {1'b1, 10'd0, 3'b111});
      @(negedge clk);
    end
    ready_mode = 2;
    wait_halt("stall", hpc, herr);
    ready_mode = 0;

    // reset mid forward scan
    expq.delete();
    load("[+++].");
    clear_tape();
    pulse_start();
    @(negedge clk);
    chk("scan_entered", {busy, rom_addr}, {1'b1, 10'd1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("scan_rst", {busy, halted, unmatched_err, rom_addr}, 13'd0);
    run_prog("[+++].", ran);

    // reset wins over start
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_over_start", {busy, halted, rom_addr}, 12'd0);

    done = 0;
    for (int n = 0; n < 200 && done < 40; n++) begin
      string s;
      int len;
      s = "";
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        int k;
        k = $urandom_range(alpha.len() - 1);
        s = {s, alpha.substr(k, k)};
      end
      run_prog(s, ran);
      if (ran) done++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
